// File: rtl/avalon_accum_slave.sv
// avalon_accum_slave: Avalon-MM slave that accumulates the slide switches
// on each debounced key press, with sticky overflow and level interrupt.
module avalon_accum_slave #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   output logic [31:0] avs_readdata,
   input  logic [7:0]  sw,
   input  logic        key_n,
   output logic [7:0]  led,
   output logic        irq
);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

   logic [7:0]    sw_s1_q, sw_s2_q;
   logic          key_s1_q, key_s2_q;
   logic [1:0]    fill_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          deb_q, deb_d, deb_last_q;
   logic          arm_q, arm_d;
   logic [15:0]   acc_q, acc_d;
   logic [15:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          ien_q, ien_d;
   logic          irq_q, irq_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   rmux;
   logic [16:0]   sum;
   logic          press, ovf_set, ovf_clr;
   logic          wr_acc, wr_stat, wr_cnt;
   logic          unused_in;

   assign unused_in = ^{avs_writedata[31:16], avs_byteenable[3:2]};

   assign wr_acc  = avs_write & (avs_address == 2'd0);
   assign wr_stat = avs_write & (avs_address == 2'd2);
   assign wr_cnt  = avs_write & (avs_address == 2'd3);

   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (key_s2_q != deb_q) begin
         if (cnt_q == CMAX) deb_d = key_s2_q;
         else               cnt_d = cnt_q + CW'(1);
      end
   end

   // A key held through reset must be seen released before it may count.
   assign arm_d = arm_q | (fill_q[1] & key_s2_q);
   assign press = deb_last_q & ~deb_q & arm_q;
   assign sum   = {1'b0, acc_q} + {9'b0, sw_s2_q};

   always_comb begin
      acc_d   = acc_q;
      ovf_set = 1'b0;
      if (wr_acc) begin
         if (avs_byteenable[0]) acc_d[7:0]  = avs_writedata[7:0];
         if (avs_byteenable[1]) acc_d[15:8] = avs_writedata[15:8];
      end else if (press) begin
         acc_d   = sum[15:0];
         ovf_set = sum[16];
      end
   end

   assign ovf_clr = wr_stat & avs_byteenable[0] & avs_writedata[0];
   assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
   assign ien_d   = (wr_stat & avs_byteenable[0]) ? avs_writedata[1] : ien_q;
   assign count_d = (wr_cnt ? 16'h0 : count_q) + {15'b0, press};
   assign irq_d   = ovf_d & ien_d;

   always_comb begin
      rmux = '0;
      unique case (avs_address)
         2'd0: rmux = {16'h0, acc_q};
         2'd1: rmux = {24'h0, sw_s2_q};
         2'd2: rmux = {29'h0, deb_q, ien_q, ovf_q};
         2'd3: rmux = {16'h0, count_q};
         default: rmux = '0;
      endcase
   end

   assign rdata_d = avs_read ? rmux : rdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         key_s1_q   <= 1'b1;
         key_s2_q   <= 1'b1;
         fill_q     <= '0;
         cnt_q      <= '0;
         deb_q      <= 1'b1;
         deb_last_q <= 1'b1;
         arm_q      <= 1'b0;
         acc_q      <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         ien_q      <= 1'b0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         sw_s1_q    <= sw;
         sw_s2_q    <= sw_s1_q;
         key_s1_q   <= key_n;
         key_s2_q   <= key_s1_q;
         fill_q     <= {fill_q[0], 1'b1};
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         deb_last_q <= deb_q;
         arm_q      <= arm_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         ien_q      <= ien_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
      end
   end

   assign avs_readdata = rdata_q;
   assign led          = acc_q[7:0];
   assign irq          = irq_q;

endmodule

// File: doc/avalon_accum_slave.md
AVALON_ACCUM_SLAVE -- requirements
Module: avalon_accum_slave

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz).
REQ-002 clk  input  1  system clock; the 50 MHz board clock, same domain as the processor bus.
REQ-003 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-004 avs_address  input  2  word address of the slave register.
REQ-005 avs_read  input  1  read strobe.
REQ-006 avs_write  input  1  write strobe.
REQ-007 avs_writedata  input  32  write data.
REQ-008 avs_byteenable  input  4  byte lanes enabled for a write.
REQ-009 avs_readdata  output  32  read data, registered.
REQ-010 sw  input  8  raw slide switches, asynchronous to clk.
REQ-011 key_n  input  1  raw accumulate push-button, active-low, bouncy.
REQ-012 led  output  8  accumulator low byte.
REQ-013 irq  output  1  interrupt request, active-high level.

Function
REQ-014 Bus is Avalon-MM slave, fixed read latency 1, no waitrequest; every access completes in one cycle.
REQ-015 Register map: 0 ACC (RW, 16 bits in [15:0]); 1 SW (RO, [7:0]); 2 STATUS; 3 COUNT (16 bits in [15:0]); unused bits read 0.
REQ-016 avs_readdata is updated on the cycle after avs_read is sampled high and holds its value otherwise.
REQ-017 A read returns the register value from before any write sampled in the same cycle.
REQ-018 ACC write: each byte lane in [15:0] is updated only where avs_byteenable is set; lanes 2-3 are ignored.
REQ-019 SW write: ignored.
REQ-020 STATUS bit0 OVF: sticky; set by accumulate carry-out; writing 1 to bit0 clears it; a set and a clear in the same cycle leave it set.
REQ-021 STATUS bit1 IRQ_EN: read/write when byte lane 0 is enabled.
REQ-022 STATUS bit2: debounced key level, read-only.
REQ-023 COUNT write, any data, clears COUNT to 0.
REQ-024 sw and key_n each pass through a 2-flop synchronizer before any other use.
REQ-025 Debouncer: while the synchronized key differs from the debounced level, a counter increments; at DEBOUNCE_CYCLES the debounced level takes the synchronized value and the counter clears.
REQ-026 Debouncer: any return of the synchronized key to the debounced level clears the counter.
REQ-027 A press event is a debounced 1->0 transition, one cycle wide; release generates nothing.
REQ-028 Press event: ACC <= (ACC + zero-extended synchronized sw) mod 2^16; carry-out sets OVF; COUNT increments mod 2^16.
REQ-029 Latency: a clean key_n fall at edge 0 updates ACC at edge DEBOUNCE_CYCLES+3.
REQ-030 Bus write to ACC and press event in the same cycle: the bus write wins ACC; COUNT still increments and OVF is unaffected.
REQ-031 Bus write to COUNT and press event in the same cycle: COUNT becomes 1.
REQ-032 led = ACC[7:0], combinational from the register.
REQ-033 irq = OVF & IRQ_EN, derived from registers with no glitching path.
REQ-034 A held key produces exactly one press event per debounced press.

Reset
REQ-035 On reset_n low, asynchronously clear ACC, COUNT, OVF, IRQ_EN, avs_readdata, the synchronizers' sw stages and the debounce counter.
REQ-036 On reset_n low, set the key synchronizer stages and debounced level to 1 (released).
REQ-037 Reset values: led=0x00, irq=0.
REQ-038 A key held low through reset release produces no press event until it is released and pressed again.

Verification (DEBOUNCE_CYCLES=4)
REQ-039 Assert reset_n mid-press with ACC=0x1234 -> same cycle led=0x00, irq=0; after release, all reads return 0 and STATUS=0x4.
REQ-040 sw=0x05, key_n low for 20 cycles -> ACC=0x0005 at edge 7, COUNT=1, led=0x05; release then re-press -> ACC=0x000A, COUNT=2.
REQ-041 key_n low-pulses of 2 cycles, 3 times, gaps of 2 cycles -> ACC and COUNT unchanged.
REQ-042 Write ACC=0xFFFE, STATUS=0x2, sw=0x03, press -> ACC=0x0001, OVF=1, irq=1; write STATUS=0x3 -> OVF stays 0, irq=0.
REQ-043 ACC=0xAB00, write 0x12340056 with be=0001 -> ACC=0xAB56; read of address 1 with sw=0x5A -> readdata=0x0000005A one cycle later.
REQ-044 Write ACC=0x0100 in the press-event cycle -> ACC=0x0100, COUNT increments by 1.
